ad7606_frame_packer: RTL and testbench
======================================

// Module: ad7606_frame_packer
// PURPOSE
//  Downstream of AD7606_ctrl. Captures the eight 16-bit two's-complement channel words
//  (ch1..ch8) on each update strobe. Block-averages 2**AVG_LOG2 consecutive frames per
//  channel, then streams the averaged frame as eight beats on a valid/ready interface,
//  ch1 first. Complete frames arriving while the previous frame is still streaming are
//  dropped and counted.
// PARAMETERS
//  AVG_LOG2  2   log2 of frames averaged per output frame; legal 0..8 (0 = pass-through)
//  DW        16  channel word width; fixed by the ADC
// PORTS
//  clk        in   1   system clock (50 MHz domain of AD7606_ctrl)
//  rst_n      in   1   asynchronous active-low reset
//  update     in   1   one-cycle pulse; ch1..ch8 are valid in the same cycle
//  ch1..ch8   in   16  signed channel samples from AD7606_ctrl
//  clr        in   1   synchronous clear of the averaging state
//  m_data     out  16  averaged sample of the current beat
//  m_chan     out  3   channel index of the beat; 0 = ch1 .. 7 = ch8
//  m_valid    out  1   beat valid
//  m_ready    in   1   sink accepts a beat when m_valid && m_ready
//  m_first    out  1   high on the ch1 beat
//  m_last     out  1   high on the ch8 beat
//  overrun    out  1   one-cycle pulse when a complete frame is dropped
//  drop_cnt   out  16  count of dropped frames; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: every register and output is 0. This includes accumulators, frame counter,
//   state=IDLE, m_valid, m_data, m_chan, m_first, m_last, overrun and drop_cnt.
//  Accumulate: 8 signed accumulators, each DW+AVG_LOG2 bits wide, plus a frame counter fcnt.
//   - On update with fcnt==0: acc[i] <= sext(ch[i]). Otherwise acc[i] <= acc[i] + sext(ch[i]).
//   - Overflow is impossible by width choice.
//   - fcnt increments on every update and wraps at 2**AVG_LOG2.
//   - The update that wraps fcnt completes a frame. avg[i] = (acc+ch) >>> AVG_LOG2
//     (arithmetic shift, rounds toward -inf), truncated to DW bits. It is registered
//     together with a one-cycle flag done.
//  clr: takes effect on the same edge and forces fcnt<=0. A partial frame is discarded.
//   clr wins over a simultaneous update, and that update is ignored. clr never aborts a
//   frame already in SEND.
//  FSM IDLE/SEND, beat index idx (3 bits):
//   - IDLE: if done, load out_buf[0..7] <= avg, set idx<=0, go to SEND.
//   - SEND: m_valid=1, m_data=out_buf[idx], m_chan=idx, m_first=(idx==0), m_last=(idx==7).
//     On handshake idx++. A handshake at idx==7 returns to IDLE.
//   - While m_valid && !m_ready, m_data, m_chan, m_first and m_last hold stable.
//  Latency: update sampled at edge E (frame-completing) -> done set at E.
//   out_buf loaded and m_valid high after edge E+1. Nominal is 2 edges from update to first beat.
//  Overrun: done in SEND, unless it coincides with the idx==7 handshake. The frame is
//   dropped, overrun pulses for 1 cycle, drop_cnt++ (saturating), and the current stream
//   is unaffected.
//  Simultaneous events:
//   - done on the same cycle as the idx==7 handshake: the new frame is loaded, the block
//     stays in SEND with idx=0, and there is no overrun.
//   - Accumulation continues during SEND regardless of backpressure.
//  Reset mid-operation: asynchronous return to reset values. A partially streamed frame
//   is lost, and no m_last is emitted.
// TESTING
//  T1 AVG_LOG2=0, m_ready=1, one update with ch1..ch8=1..8 -> beats 1..8 on consecutive
//     cycles; m_chan 0..7; m_first on the 1st beat, m_last on the 8th; m_valid 2 edges
//     after update.
//  T2 AVG_LOG2=2, four updates ch1=100,101,102,103 and ch2=-1,-1,-1,-2 -> one frame with
//     ch1=101 and ch2=-2 (-5>>>2); no output after updates 1-3.
//  T3 Backpressure: drop m_ready for 5 cycles at beat 3 -> m_data/m_chan held; all 8 beats
//     delivered once, in order.
//  T4 Overrun: m_ready=0, complete two frames -> the first is held; overrun pulses once;
//     drop_cnt=1; after release only the first frame is streamed.
//  T5 Coincidence: complete a frame on the exact cycle of the idx==7 handshake -> the next
//     cycle shows m_valid, m_first, the new ch1 value; overrun stays 0.
//  T6 clr after 2 of 4 updates, then 4 fresh updates -> output equals the average of the
//     fresh 4 only. Assert rst_n low at beat 4 -> all outputs 0 immediately; fcnt=0.

Source files
------------

// File: rtl/ad7606_frame_packer.sv
// ad7606_frame_packer: block-averages AD7606 frames and streams them as 8 valid/ready beats
module ad7606_frame_packer #(
  parameter int AVG_LOG2 = 2,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          update,
  input  logic [DW-1:0] ch1,
  input  logic [DW-1:0] ch2,
  input  logic [DW-1:0] ch3,
  input  logic [DW-1:0] ch4,
  input  logic [DW-1:0] ch5,
  input  logic [DW-1:0] ch6,
  input  logic [DW-1:0] ch7,
  input  logic [DW-1:0] ch8,
  input  logic          clr,
  output logic [DW-1:0] m_data,
  output logic [2:0]    m_chan,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_first,
  output logic          m_last,
  output logic          overrun,
  output logic [15:0]   drop_cnt
);
  localparam int AW = DW + AVG_LOG2;
  localparam int FW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [7:0][DW-1:0] ch, avg, avg_n, out_buf;
  logic [7:0][AW-1:0] acc, sum;
  logic [FW-1:0] fcnt;
  logic [2:0] idx;
  logic wrap, done, hs, last_hs, load, ovr;
  assign ch = {ch8, ch7, ch6, ch5, ch4, ch3, ch2, ch1};
  assign wrap = fcnt == FW'((1 << AVG_LOG2) - 1);
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sum[i] = (fcnt == '0 ? '0 : acc[i]) + AW'(signed'(ch[i]));
      avg_n[i] = DW'(signed'(sum[i]) >>> AVG_LOG2);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      fcnt <= '0;
      avg <= '0;
      done <= 1'b0;
    end else begin
      done <= update && !clr && wrap;
      if (clr) fcnt <= '0;
      else if (update) begin
        acc <= sum;
        fcnt <= wrap ? '0 : fcnt + 1'b1;
        if (wrap) avg <= avg_n;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // a frame finishing on the final handshake reloads instead of being dropped
  always_comb begin
    hs = state == SEND && m_ready;
    last_hs = hs && idx == 3'd7;
    load = done && (state == IDLE || last_hs);
    ovr = done && state == SEND && !last_hs;
    state_n = load ? SEND : last_hs ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_buf <= '0;
      idx <= '0;
      overrun <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (load) begin
        out_buf <= avg;
        idx <= '0;
      end else if (hs) idx <= idx + 3'd1;
      overrun <= ovr;
      if (ovr && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end
  assign m_valid = state == SEND;
  assign m_data = m_valid ? out_buf[idx] : '0;
  assign m_chan = idx;
  assign m_first = m_valid && idx == 3'd0;
  assign m_last = m_valid && idx == 3'd7;
endmodule

// File: tb/tb_ad7606_frame_packer.sv
// tb_ad7606_frame_packer: directed stimulus with a queue scoreboard and decoupled beat monitors
module tb_ad7606_frame_packer;
  logic clk = 0, rst_n = 0, ua = 0, ub = 0, clr = 0, ready_a = 1, ready_b = 1;
  logic [15:0] c [8];
  logic [15:0] a_data, b_data, a_drop, b_drop;
  logic [2:0] a_chan, b_chan;
  logic a_valid, b_valid, a_first, b_first, a_last, b_last, a_ovr, b_ovr;
  logic [20:0] qa [$], qb [$];
  logic [20:0] held_b;
  logic stall_b = 0;
  int n_chk = 0, n_fail = 0, ov_b = 0;

  always #5 clk = ~clk;

  ad7606_frame_packer #(.AVG_LOG2(0), .DW(16)) u_a (
    .clk(clk), .rst_n(rst_n), .update(ua),
    .ch1(c[0]), .ch2(c[1]), .ch3(c[2]), .ch4(c[3]), .ch5(c[4]), .ch6(c[5]), .ch7(c[6]), .ch8(c[7]),
    .clr(clr), .m_data(a_data), .m_chan(a_chan), .m_valid(a_valid), .m_ready(ready_a),
    .m_first(a_first), .m_last(a_last), .overrun(a_ovr), .drop_cnt(a_drop));

  ad7606_frame_packer #(.AVG_LOG2(2), .DW(16)) u_b (
    .clk(clk), .rst_n(rst_n), .update(ub),
    .ch1(c[0]), .ch2(c[1]), .ch3(c[2]), .ch4(c[3]), .ch5(c[4]), .ch6(c[5]), .ch7(c[6]), .ch8(c[7]),
    .clr(clr), .m_data(b_data), .m_chan(b_chan), .m_valid(b_valid), .m_ready(ready_b),
    .m_first(b_first), .m_last(b_last), .overrun(b_ovr), .drop_cnt(b_drop));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [20:0] act, exp;
    act = {a_first, a_last, a_chan, a_data};
    if (a_valid && ready_a) begin
      n_chk++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL a_beat: unexpected beat %h", act);
      end else begin
        exp = qa.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL a_beat: got %h expected %h", act, exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [20:0] act, exp;
    act = {b_first, b_last, b_chan, b_data};
    if (b_ovr) ov_b++;
    if (b_valid && ready_b) begin
      n_chk++;
      if (qb.size() == 0) begin
        n_fail++;
        $display("FAIL b_beat: unexpected beat %h", act);
      end else begin
        exp = qb.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL b_beat: got %h expected %h", act, exp);
        end
      end
    end
    if (stall_b) begin
      n_chk++;
      if (act !== held_b || !b_valid) begin
        n_fail++;
        $display("FAIL b_hold: got %h valid %b expected %h valid 1", act, b_valid, held_b);
      end
    end
    stall_b = b_valid && !ready_b;
    held_b = act;
  end

  task automatic upd(input int a1, input int a2, input int ar);
    c[0] = 16'(a1);
    c[1] = 16'(a2);
    for (int i = 2; i < 8; i++) c[i] = 16'(ar);
    ub = 1;
    @(posedge clk);
    #1 ub = 0;
  endtask

  task automatic push_b(input int a1, input int a2, input int ar);
    for (int i = 0; i < 8; i++)
      qb.push_back({i == 0, i == 7, 3'(i), 16'(i == 0 ? a1 : i == 1 ? a2 : ar)});
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100 && (qa.size() != 0 || qb.size() != 0); k++) begin
      @(posedge clk);
      #1;
    end
    if (k == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d/%0d beats missing, required 0", qa.size(), qb.size());
    end
  endtask

  task automatic wait_chan(input logic [2:0] ch);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (b_valid && b_chan == ch) break;
    end
    if (k == 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_chan: beat %0d never shown", ch);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) c[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", b_valid, 0);
    chk("rst_data", b_data, 0);
    chk("rst_drop", b_drop, 0);
    chk("rst_ovr", b_ovr, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    // T1: pass-through instance, latency and framing
    for (int i = 0; i < 8; i++) begin
      c[i] = 16'(i + 1);
      qa.push_back({i == 0, i == 7, 3'(i), 16'(i + 1)});
    end
    ua = 1;
    @(posedge clk);
    #1 ua = 0;
    chk("t1_valid_e0", a_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid_e1", a_valid, 1);
    chk("t1_first", a_first, 1);
    chk("t1_data", a_data, 1);
    drain();
    // T2: 4-frame average with negative rounding toward -inf
    upd(100, -1, 0);
    chk("t2_noout1", b_valid, 0);
    upd(101, -1, 0);
    chk("t2_noout2", b_valid, 0);
    upd(102, -1, 0);
    chk("t2_noout3", b_valid, 0);
    push_b(101, -2, 0);
    upd(103, -2, 0);
    chk("t2_valid_e0", b_valid, 0);
    @(posedge clk);
    #1;
    chk("t2_valid_e1", b_valid, 1);
    drain();
    // T3: backpressure at beat 3
    push_b(10, 20, 30);
    repeat (4) upd(10, 20, 30);
    wait_chan(2);
    ready_b = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("t3_chan", b_chan, 2);
    chk("t3_data", b_data, 30);
    ready_b = 1;
    drain();
    // T4: second frame dropped while the first is stalled
    ov_b = 0;
    ready_b = 0;
    push_b(1, 2, 3);
    repeat (4) upd(1, 2, 3);
    repeat (4) upd(5, 6, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_ovr_pulses", ov_b, 1);
    chk("t4_drop", b_drop, 1);
    chk("t4_held", b_data, 1);
    ready_b = 1;
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("t4_idle", b_valid, 0);
    // T5: new frame completes on the final handshake
    ov_b = 0;
    push_b(11, 12, 13);
    push_b(21, 22, 23);
    repeat (4) upd(11, 12, 13);
    repeat (3) upd(21, 22, 23);
    wait_chan(6);
    upd(21, 22, 23);
    chk("t5_last", b_last, 1);
    @(posedge clk);
    #1;
    chk("t5_valid", b_valid, 1);
    chk("t5_first", b_first, 1);
    chk("t5_data", b_data, 21);
    drain();
    chk("t5_no_ovr", ov_b, 0);
    // T6: clr discards partial frame and beats a simultaneous update
    push_b(5, -3, -1);
    repeat (2) upd(1000, 1000, 1000);
    clr = 1;
    upd(2000, 2000, 2000);
    clr = 0;
    upd(4, -3, -1);
    upd(5, -3, -1);
    upd(6, -3, -1);
    upd(7, -3, -1);
    upd(99, 99, 99);
    wait_chan(3);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", b_valid, 0);
    chk("t6_rst_data", b_data, 0);
    chk("t6_rst_chan", b_chan, 0);
    chk("t6_rst_first", b_first, 0);
    chk("t6_rst_last", b_last, 0);
    chk("t6_rst_ovr", b_ovr, 0);
    chk("t6_rst_drop", b_drop, 0);
    chk("t6_beats_left", qb.size(), 5);
    qb.delete();
    @(posedge clk);
    #1 rst_n = 1;
    push_b(40, -40, 7);
    repeat (4) upd(40, -40, 7);
    drain();
    chk("t6_no_ovr", ov_b, 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
